alu_seq: RTL and testbench

//  Parametrised successor to the 32-bit combinational ALU. Adds a valid/ready handshake on

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_seq_if.sv | 30 +++
 rtl/alu_mul_iter.sv | 57 +++++
 rtl/alu_seq.sv | 154 +++++++++++++++
 tb/tb_alu_seq.sv | 337 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: operation codes, FSM states
// and a small helper to recognise the multi-cycle operations.
package alu_pkg;

    localparam int OP_W = 4;

    localparam logic [OP_W-1:0] OP_ADD   = 4'h0;
    localparam logic [OP_W-1:0] OP_SUB   = 4'h1;
    localparam logic [OP_W-1:0] OP_AND   = 4'h2;
    localparam logic [OP_W-1:0] OP_OR    = 4'h3;
    localparam logic [OP_W-1:0] OP_XOR   = 4'h4;
    localparam logic [OP_W-1:0] OP_SLL   = 4'h5;
    localparam logic [OP_W-1:0] OP_SRL   = 4'h6;
    localparam logic [OP_W-1:0] OP_SRA   = 4'h7;
    localparam logic [OP_W-1:0] OP_SLT   = 4'h8;
    localparam logic [OP_W-1:0] OP_SLTU  = 4'h9;
    localparam logic [OP_W-1:0] OP_MUL   = 4'hA;
    localparam logic [OP_W-1:0] OP_MULHU = 4'hB;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    // True for the two opcodes that go through the iterative multiplier.
    function automatic logic is_mul_op(input logic [OP_W-1:0] op);
        return (op == OP_MUL) || (op == OP_MULHU);
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Operand and result handshake bundle between issue logic, the ALU and the
// writeback mux. The master side supplies operands and consumes results.
interface alu_seq_if import alu_pkg::*; #(
    parameter int WIDTH = 32
) ();

    logic             in_valid;
    logic             in_ready;
    logic [OP_W-1:0]  op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] x;
    logic             zero;
    logic             neg;
    logic             carry;
    logic             ovf;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, x, zero, neg, carry, ovf
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, x, zero, neg, carry, ovf
    );

endinterface

// File: rtl/alu_mul_iter.sv
// Unsigned shift-add multiplier, one multiplier bit per cycle.
// The product register shifts right each step; prod presents the value the
// register will hold after the current step, so on the final step (done) the
// full product is available to the parent at the same edge.
module alu_mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] prod
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   sum;

    assign addend = lo[0] ? mcand : '0;
    assign sum    = {1'b0, hi} + {1'b0, addend};
    assign prod   = {sum, lo[WIDTH-1:1]};
    assign done   = busy && (cnt == LAST);

    // Load operands on start, then perform one add-and-shift step per cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy  <= 1'b0;
            cnt   <= '0;
            mcand <= '0;
            hi    <= '0;
            lo    <= '0;
        end else if (start) begin
            busy  <= 1'b1;
            cnt   <= '0;
            mcand <= a;
            hi    <= '0;
            lo    <= b;
        end else if (busy) begin
            hi  <= sum[WIDTH:1];
            lo  <= {sum[0], lo[WIDTH-1:1]};
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshakes on both sides, registered
// result and flags, and an optional iterative multiplier for MUL/MULHU.
module alu_seq import alu_pkg::*; #(
    parameter int WIDTH  = 32,
    parameter bit MUL_EN = 1'b1
) (
    input  logic      clk,
    input  logic      rst,
    alu_seq_if.slave  bus
);

    localparam int SHW = $clog2(WIDTH);

    state_t             state;
    logic               hi_sel;
    logic               out_valid_r;
    logic [WIDTH-1:0]   x_r;
    logic               zero_r;
    logic               neg_r;
    logic               carry_r;
    logic               ovf_r;

    logic               accept;
    logic               op_is_mul;
    logic               mul_start;
    logic               mul_busy;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_prod;
    logic [WIDTH-1:0]   mul_x;

    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [SHW-1:0]     shamt;
    logic [WIDTH-1:0]   comb_x;
    logic               comb_carry;
    logic               comb_ovf;

    assign op_is_mul = MUL_EN && is_mul_op(bus.op);
    assign bus.in_ready = !rst && (state == S_IDLE) && !mul_busy
                          && (!out_valid_r || bus.out_ready);
    assign accept    = bus.in_valid && bus.in_ready;
    assign mul_start = accept && op_is_mul;

    assign sum   = {1'b0, bus.a} + {1'b0, bus.b};
    assign diff  = {1'b0, bus.a} - {1'b0, bus.b};
    assign shamt = bus.b[SHW-1:0];
    assign mul_x = hi_sel ? mul_prod[2*WIDTH-1:WIDTH] : mul_prod[WIDTH-1:0];

    assign bus.out_valid = out_valid_r;
    assign bus.x         = x_r;
    assign bus.zero      = zero_r;
    assign bus.neg       = neg_r;
    assign bus.carry     = carry_r;
    assign bus.ovf       = ovf_r;

    // Single-cycle datapath; reserved opcodes (and MUL ops here) yield zero.
    always_comb begin
        comb_x     = '0;
        comb_carry = 1'b0;
        comb_ovf   = 1'b0;
        case (bus.op)
            OP_ADD: begin
                comb_x     = sum[WIDTH-1:0];
                comb_carry = sum[WIDTH];
                comb_ovf   = (bus.a[WIDTH-1] == bus.b[WIDTH-1])
                             && (sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB: begin
                comb_x     = diff[WIDTH-1:0];
                comb_carry = !diff[WIDTH];
                comb_ovf   = (bus.a[WIDTH-1] != bus.b[WIDTH-1])
                             && (diff[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_AND:  comb_x = bus.a & bus.b;
            OP_OR:   comb_x = bus.a | bus.b;
            OP_XOR:  comb_x = bus.a ^ bus.b;
            OP_SLL:  comb_x = bus.a << shamt;
            OP_SRL:  comb_x = bus.a >> shamt;
            OP_SRA:  comb_x = WIDTH'($signed(bus.a) >>> shamt);
            OP_SLT:  comb_x = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            OP_SLTU: comb_x = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
            default: comb_x = '0;
        endcase
    end

    // The multiplier exists only when MUL/MULHU are implemented.
    generate
        if (MUL_EN) begin : g_mul
            alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
                .clk   (clk),
                .rst   (rst),
                .start (mul_start),
                .a     (bus.a),
                .b     (bus.b),
                .busy  (mul_busy),
                .done  (mul_done),
                .prod  (mul_prod)
            );
        end else begin : g_no_mul
            assign mul_busy = 1'b0;
            assign mul_done = 1'b0;
            assign mul_prod = '0;
        end
    endgenerate

    // Control FSM and output holding register: single-cycle results load on
    // accept, multiply results load on the final iteration.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            hi_sel      <= 1'b0;
            out_valid_r <= 1'b0;
            x_r         <= '0;
            zero_r      <= 1'b0;
            neg_r       <= 1'b0;
            carry_r     <= 1'b0;
            ovf_r       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (op_is_mul) begin
                            state       <= S_MUL;
                            hi_sel      <= (bus.op == OP_MULHU);
                            out_valid_r <= 1'b0;
                        end else begin
                            out_valid_r <= 1'b1;
                            x_r         <= comb_x;
                            zero_r      <= (comb_x == '0);
                            neg_r       <= comb_x[WIDTH-1];
                            carry_r     <= comb_carry;
                            ovf_r       <= comb_ovf;
                        end
                    end else if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                    end
                end
                S_MUL: begin
                    if (mul_done) begin
                        state       <= S_IDLE;
                        out_valid_r <= 1'b1;
                        x_r         <= mul_x;
                        zero_r      <= (mul_x == '0);
                        neg_r       <= mul_x[WIDTH-1];
                        carry_r     <= 1'b0;
                        ovf_r       <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: a 32-bit instance with the multiplier and an 8-bit
// instance without it share one set of stimulus variables; sel8 picks which
// one is driven and observed. Expected results come from an arithmetic
// reference model and a queue of outstanding results.
module tb_alu_seq;
    import alu_pkg::*;

    typedef struct packed {
        logic [31:0] x;
        logic [3:0]  f;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        sel8        = 1'b0;
    logic        in_valid_s  = 1'b0;
    logic        out_ready_s = 1'b1;
    logic [3:0]  op_s        = 4'h0;
    logic [31:0] a_s         = '0;
    logic [31:0] b_s         = '0;

    logic        obs_valid;
    logic        obs_in_ready;
    logic [31:0] obs_x;
    logic [3:0]  obs_flags;

    int checks = 0;
    int errors = 0;

    alu_seq_if #(.WIDTH(32)) bus32 ();
    alu_seq_if #(.WIDTH(8))  bus8 ();

    alu_seq #(.WIDTH(32), .MUL_EN(1'b1)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
    alu_seq #(.WIDTH(8),  .MUL_EN(1'b0)) dut8  (.clk(clk), .rst(rst), .bus(bus8));

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    assign bus32.in_valid  = in_valid_s && !sel8;
    assign bus32.op        = op_s;
    assign bus32.a         = a_s;
    assign bus32.b         = b_s;
    assign bus32.out_ready = out_ready_s;
    assign bus8.in_valid   = in_valid_s && sel8;
    assign bus8.op         = op_s;
    assign bus8.a          = a_s[7:0];
    assign bus8.b          = b_s[7:0];
    assign bus8.out_ready  = out_ready_s;

    assign obs_valid    = sel8 ? bus8.out_valid : bus32.out_valid;
    assign obs_in_ready = sel8 ? bus8.in_ready  : bus32.in_ready;
    assign obs_x        = sel8 ? {24'h0, bus8.x} : bus32.x;
    assign obs_flags    = sel8 ? {bus8.zero, bus8.neg, bus8.carry, bus8.ovf}
                               : {bus32.zero, bus32.neg, bus32.carry, bus32.ovf};

    // Counts one comparison and reports it when observed differs from expected.
    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: the operation evaluated on w-bit integers with 64-bit arithmetic.
    function automatic res_t model(input int w, input bit mul_en, input logic [3:0] op,
                                   input logic [31:0] a, input logic [31:0] b);
        longint unsigned m, ua, ub, r;
        longint          sa, sb, ss, smax, smin;
        int              sh;
        bit              c, v, z, n;
        res_t            res;
        m    = (64'd1 << w) - 64'd1;
        ua   = 64'(a) & m;
        ub   = 64'(b) & m;
        sa   = (((ua >> (w-1)) & 64'd1) != 0) ? $signed(ua) - (64'sd1 <<< w) : $signed(ua);
        sb   = (((ub >> (w-1)) & 64'd1) != 0) ? $signed(ub) - (64'sd1 <<< w) : $signed(ub);
        smax = (64'sd1 <<< (w-1)) - 64'sd1;
        smin = -(64'sd1 <<< (w-1));
        sh   = int'(ub & 64'(w-1));
        c = 1'b0; v = 1'b0; r = 0;
        case (op)
            OP_ADD:   begin r = ua + ub; c = (r >> w) != 0; ss = sa + sb; v = (ss > smax) || (ss < smin); end
            OP_SUB:   begin r = ua - ub; c = ua >= ub;      ss = sa - sb; v = (ss > smax) || (ss < smin); end
            OP_AND:   r = ua & ub;
            OP_OR:    r = ua | ub;
            OP_XOR:   r = ua ^ ub;
            OP_SLL:   r = ua << sh;
            OP_SRL:   r = ua >> sh;
            OP_SRA:   r = $unsigned(sa >>> sh);
            OP_SLT:   r = (sa < sb) ? 1 : 0;
            OP_SLTU:  r = (ua < ub) ? 1 : 0;
            OP_MUL:   r = mul_en ? ua * ub : 0;
            OP_MULHU: r = mul_en ? (ua * ub) >> w : 0;
            default:  r = 0;
        endcase
        r = r & m;
        z = (r == 0);
        n = ((r >> (w-1)) & 64'd1) != 0;
        res.x = r[31:0];
        res.f = {z, n, c, v};
        return res;
    endfunction

    // Operand picker biased towards boundary values of a w-bit word.
    function automatic logic [31:0] pickVal(input int w);
        logic [31:0] msb;
        msb = 32'd1 << (w-1);
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return msb;
            3:       return msb - 32'd1;
            4:       return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    // Presents one operand beat and holds it until the selected DUT accepts it.
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bit taken;
        taken = 1'b0;
        @(posedge clk); #1;
        op_s = op; a_s = a; b_s = b; in_valid_s = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (obs_in_ready) begin
                taken = 1'b1;
                break;
            end
        end
        if (!taken) checkOutput("accept_timeout", 64'(taken), 64'd1);
        @(posedge clk); #1;
        in_valid_s = 1'b0;
    endtask

    // Cycles from the accept edge until out_valid is seen; notes any in_ready before it.
    task automatic measureLatency(output int lat, output bit rdy_seen);
        lat = -1;
        rdy_seen = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (obs_valid) begin
                lat = i;
                break;
            end
            if (obs_in_ready) rdy_seen = 1'b1;
        end
    endtask

    // Random operand stream with random backpressure against a result queue.
    task automatic runRandom(input int cycles, input int w, input bit mul_en);
        res_t q[$];
        res_t e;
        bit   accepted;
        in_valid_s  = 1'b0;
        out_ready_s = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int cyc = 0; cyc < cycles; cyc++) begin
            @(negedge clk);
            accepted = 1'b0;
            if (obs_valid && out_ready_s) begin
                if (q.size() == 0) begin
                    checkOutput("rnd_unexpected_beat", 64'd1, 64'd0);
                end else begin
                    e = q.pop_front();
                    checkOutput("rnd_x", 64'(obs_x), 64'(e.x));
                    checkOutput("rnd_flags", 64'(obs_flags), 64'(e.f));
                end
            end
            if (in_valid_s && obs_in_ready) begin
                q.push_back(model(w, mul_en, op_s, a_s, b_s));
                accepted = 1'b1;
            end
            @(posedge clk); #1;
            if (!in_valid_s || accepted) begin
                in_valid_s = ($urandom_range(0, 3) != 0);
                op_s       = 4'($urandom_range(0, 15));
                a_s        = pickVal(w);
                b_s        = pickVal(w);
            end
            out_ready_s = ($urandom_range(0, 3) != 0);
        end
        in_valid_s  = 1'b0;
        out_ready_s = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (obs_valid) begin
                if (q.size() == 0) begin
                    checkOutput("rnd_unexpected_beat", 64'd1, 64'd0);
                end else begin
                    e = q.pop_front();
                    checkOutput("rnd_x", 64'(obs_x), 64'(e.x));
                    checkOutput("rnd_flags", 64'(obs_flags), 64'(e.f));
                end
            end else if (q.size() == 0) begin
                break;
            end
        end
        checkOutput("rnd_drain_left", 64'(q.size()), 64'd0);
    endtask

    // Directed table: opcode, operands, expected result and {zero,neg,carry,ovf}.
    logic [3:0]  t_op [6] = '{OP_ADD, OP_SUB, OP_SRA, OP_SLL, OP_SLT, OP_SLTU};
    logic [31:0] t_a  [6] = '{32'h7FFF_FFFF, 32'h5, 32'h8000_0000, 32'h1, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] t_b  [6] = '{32'h1, 32'h5, 32'h0000_0024, 32'd31, 32'h1, 32'h1};
    logic [31:0] t_x  [6] = '{32'h8000_0000, 32'h0, 32'hF800_0000, 32'h8000_0000, 32'h1, 32'h0};
    logic [3:0]  t_f  [6] = '{4'b0101, 4'b1010, 4'b0100, 4'b0100, 4'b0000, 4'b1000};

    // Main sequence.
    initial begin
        int   lat;
        bit   rdy;
        int   vcount;
        res_t r1, r2, r3;

        // Reset state while rst is high.
        @(negedge clk);
        checkOutput("rst_valid", 64'(obs_valid), 64'd0);
        checkOutput("rst_x", 64'(obs_x), 64'd0);
        checkOutput("rst_flags", 64'(obs_flags), 64'd0);
        checkOutput("rst_in_ready", 64'(obs_in_ready), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Single-cycle directed operations.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(t_op[i], t_a[i], t_b[i]);
            measureLatency(lat, rdy);
            checkOutput($sformatf("dir%0d_latency", i), 64'(lat), 64'd1);
            checkOutput($sformatf("dir%0d_x", i), 64'(obs_x), 64'(t_x[i]));
            checkOutput($sformatf("dir%0d_flags", i), 64'(obs_flags), 64'(t_f[i]));
        end

        // Multiplies: latency WIDTH+1 cycles, in_ready low while busy.
        applyStimulus(OP_MUL, 32'hFFFF_FFFF, 32'h2);
        measureLatency(lat, rdy);
        checkOutput("mul_latency", 64'(lat), 64'd33);
        checkOutput("mul_in_ready_busy", 64'(rdy), 64'd0);
        checkOutput("mul_x", 64'(obs_x), 64'hFFFF_FFFE);
        checkOutput("mul_flags", 64'(obs_flags), 64'(4'b0100));
        applyStimulus(OP_MULHU, 32'hFFFF_FFFF, 32'h2);
        measureLatency(lat, rdy);
        checkOutput("mulhu_latency", 64'(lat), 64'd33);
        checkOutput("mulhu_in_ready_busy", 64'(rdy), 64'd0);
        checkOutput("mulhu_x", 64'(obs_x), 64'h1);

        // Backpressure: three ADDs, consumer stalls after the first result.
        r1 = model(32, 1'b1, OP_ADD, 32'h1, 32'h1);
        r2 = model(32, 1'b1, OP_ADD, 32'hFFFF_FFFF, 32'h1);
        r3 = model(32, 1'b1, OP_ADD, 32'd100, 32'd200);
        @(posedge clk); #1;
        op_s = OP_ADD; a_s = 32'h1; b_s = 32'h1; in_valid_s = 1'b1;
        @(negedge clk);
        checkOutput("bp_ready_first", 64'(obs_in_ready), 64'd1);
        @(posedge clk); #1;
        out_ready_s = 1'b0;
        a_s = 32'hFFFF_FFFF; b_s = 32'h1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput($sformatf("bp_hold%0d_valid", i), 64'(obs_valid), 64'd1);
            checkOutput($sformatf("bp_hold%0d_x", i), 64'(obs_x), 64'(r1.x));
            checkOutput($sformatf("bp_hold%0d_in_ready", i), 64'(obs_in_ready), 64'd0);
        end
        out_ready_s = 1'b1;
        @(posedge clk); #1;
        a_s = 32'd100; b_s = 32'd200;
        @(negedge clk);
        checkOutput("bp_drain2_valid", 64'(obs_valid), 64'd1);
        checkOutput("bp_drain2_x", 64'(obs_x), 64'(r2.x));
        checkOutput("bp_drain2_flags", 64'(obs_flags), 64'(r2.f));
        @(posedge clk); #1;
        in_valid_s = 1'b0;
        @(negedge clk);
        checkOutput("bp_drain3_valid", 64'(obs_valid), 64'd1);
        checkOutput("bp_drain3_x", 64'(obs_x), 64'(r3.x));
        @(negedge clk);
        checkOutput("bp_drain_done", 64'(obs_valid), 64'd0);

        // Reset during a multiply clears everything at once.
        applyStimulus(OP_MUL, 32'h1234, 32'h5678);
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        checkOutput("rstmul_valid", 64'(obs_valid), 64'd0);
        checkOutput("rstmul_x", 64'(obs_x), 64'd0);
        checkOutput("rstmul_flags", 64'(obs_flags), 64'd0);
        checkOutput("rstmul_in_ready", 64'(obs_in_ready), 64'd0);
        @(posedge clk); #1 rst = 1'b0;
        vcount = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (obs_valid) vcount++;
        end
        checkOutput("rstmul_no_stale_result", 64'(vcount), 64'd0);
        applyStimulus(OP_ADD, 32'd2, 32'd3);
        measureLatency(lat, rdy);
        checkOutput("post_rst_latency", 64'(lat), 64'd1);
        checkOutput("post_rst_x", 64'(obs_x), 64'd5);

        runRandom(800, 32, 1'b1);

        // 8-bit instance without the multiplier.
        @(posedge clk); #1;
        sel8 = 1'b1;
        applyStimulus(OP_MUL, 32'h3, 32'h4);
        measureLatency(lat, rdy);
        checkOutput("w8_opA_latency", 64'(lat), 64'd1);
        checkOutput("w8_opA_x", 64'(obs_x), 64'd0);
        checkOutput("w8_opA_flags", 64'(obs_flags), 64'(4'b1000));
        applyStimulus(4'hF, 32'h55, 32'hAA);
        measureLatency(lat, rdy);
        checkOutput("w8_opF_latency", 64'(lat), 64'd1);
        checkOutput("w8_opF_x", 64'(obs_x), 64'd0);
        checkOutput("w8_opF_flags", 64'(obs_flags), 64'(4'b1000));
        applyStimulus(OP_ADD, 32'hFF, 32'h01);
        measureLatency(lat, rdy);
        checkOutput("w8_add_latency", 64'(lat), 64'd1);
        checkOutput("w8_add_x", 64'(obs_x), 64'd0);
        checkOutput("w8_add_flags", 64'(obs_flags), 64'(4'b1010));

        runRandom(300, 8, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Upper bound on total simulated time.
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
